// File: rtl/seg_pattern_capture.sv
// Recovers digit values from an active-low, time-multiplexed 7-segment bus.
// Each slot debounces its own pattern and commits a decoded value once the pattern is stable.
module seg_pattern_capture #(
   parameter int NUM_DIGITS   = 4,
   parameter int STABLE_COUNT = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg_in,
   input  logic [2:0]              digit_idx,
   input  logic                    seg_strobe,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [NUM_DIGITS-1:0]   err_mask,
   output logic                    update,
   output logic [2:0]              update_idx
);

   localparam int CW = (STABLE_COUNT < 2) ? 1 : $clog2(STABLE_COUNT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_COUNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);
   localparam logic          ONE_SHOT = (STABLE_COUNT == 1);

   logic [3:0]            dec_value;
   logic                  dec_blank;
   logic                  dec_err;
   logic                  slot_hit;
   logic [NUM_DIGITS-1:0] commit;
   logic                  update_reg;
   logic [2:0]            update_idx_reg;

   // Exact-match decode of the raw bus; only the current strobe's slot ever uses it.
   always_comb begin
      dec_value = 4'hF;
      dec_blank = 1'b0;
      dec_err   = 1'b0;
      case (seg_in)
         7'b1000000: dec_value = 4'd0;
         7'b1111001: dec_value = 4'd1;
         7'b0100100: dec_value = 4'd2;
         7'b0110000: dec_value = 4'd3;
         7'b0011001: dec_value = 4'd4;
         7'b0010010: dec_value = 4'd5;
         7'b0000010: dec_value = 4'd6;
         7'b1111000: dec_value = 4'd7;
         7'b0000000: dec_value = 4'd8;
         7'b0010000: dec_value = 4'd9;
         7'b1111111: dec_blank = 1'b1;
         default:    dec_err   = 1'b1;
      endcase
   end

   assign slot_hit = seg_strobe && ({1'b0, digit_idx} < 4'(NUM_DIGITS));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
         logic [6:0]    cand_reg;
         logic [CW-1:0] cnt_reg;
         logic [3:0]    value_reg;
         logic          blank_reg;
         logic          err_reg;
         logic          sel;
         logic          differs;

         assign sel     = slot_hit && (digit_idx == 3'(gi));
         assign differs = (seg_in != cand_reg);
         // A new pattern restarts the run; a repeat commits only on reaching the threshold.
         assign commit[gi] = sel && (differs ? ONE_SHOT : (cnt_reg == CNT_LAST));

         always_ff @(posedge clk) begin
            if (rst) begin
               cand_reg  <= 7'b1111111;
               cnt_reg   <= '0;
               value_reg <= 4'hF;
               blank_reg <= 1'b1;
               err_reg   <= 1'b0;
            end else begin
               if (sel) begin
                  if (differs) begin
                     cand_reg <= seg_in;
                     cnt_reg  <= CW'(1);
                  end else if (cnt_reg < CNT_MAX) begin
                     cnt_reg <= cnt_reg + CW'(1);
                  end
               end
               if (commit[gi]) begin
                  value_reg <= dec_value;
                  blank_reg <= dec_blank;
                  err_reg   <= dec_err;
               end
            end
         end

         assign digits[4*gi +: 4] = value_reg;
         assign blank_mask[gi]    = blank_reg;
         assign err_mask[gi]      = err_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         update_reg     <= 1'b0;
         update_idx_reg <= 3'd0;
      end else begin
         update_reg <= |commit;
         if (|commit) begin
            update_idx_reg <= digit_idx;
         end
      end
   end

   assign update     = update_reg;
   assign update_idx = update_idx_reg;

endmodule

// File: tb/tb_seg_pattern_capture.sv
// Directed bench for seg_pattern_capture: one STABLE_COUNT=3 and one STABLE_COUNT=1 instance share stimulus,
// checked every cycle against a run-length model plus literal spot checks.
module tb_seg_pattern_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_in;
   logic [2:0]  digit_idx;
   logic        seg_strobe;

   logic [15:0] a_digits, b_digits;
   logic [3:0]  a_blank, b_blank, a_err, b_err;
   logic        a_update, b_update;
   logic [2:0]  a_idx, b_idx;

   int n_tests = 0;
   int n_fail  = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   seg_pattern_capture #(.NUM_DIGITS(4), .STABLE_COUNT(3)) dut_a (
      .clk(clk), .rst(rst), .seg_in(seg_in), .digit_idx(digit_idx), .seg_strobe(seg_strobe),
      .digits(a_digits), .blank_mask(a_blank), .err_mask(a_err), .update(a_update), .update_idx(a_idx));

   seg_pattern_capture #(.NUM_DIGITS(4), .STABLE_COUNT(1)) dut_b (
      .clk(clk), .rst(rst), .seg_in(seg_in), .digit_idx(digit_idx), .seg_strobe(seg_strobe),
      .digits(b_digits), .blank_mask(b_blank), .err_mask(b_err), .update(b_update), .update_idx(b_idx));

   logic [6:0] pat [10];
   initial begin
      pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100; pat[3] = 7'b0110000;
      pat[4] = 7'b0011001; pat[5] = 7'b0010010; pat[6] = 7'b0000010; pat[7] = 7'b1111000;
      pat[8] = 7'b0000000; pat[9] = 7'b0010000;
   end

   // Model: per slot, last seen pattern and how many times in a row it has been seen.
   logic [6:0] m_last  [2][4];
   int         m_run   [2][4];
   logic [3:0] m_val   [2][4];
   logic       m_blank [2][4];
   logic       m_err   [2][4];
   logic       m_upd   [2];
   logic [2:0] m_idx   [2];

   function automatic int sc_of(input int d);
      return (d == 0) ? 3 : 1;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            for (int k = 0; k < 4; k++) begin
               m_last[d][k] = 7'h7F; m_run[d][k] = 0;
               m_val[d][k] = 4'hF; m_blank[d][k] = 1'b1; m_err[d][k] = 1'b0;
            end
            m_upd[d] = 1'b0; m_idx[d] = 3'd0;
         end else begin
            m_upd[d] = 1'b0;
            if (seg_strobe && digit_idx < 4) begin
               int s;
               s = int'(digit_idx);
               if (seg_in != m_last[d][s]) begin
                  m_last[d][s] = seg_in; m_run[d][s] = 1;
               end else begin
                  m_run[d][s]++;
               end
               if (m_run[d][s] == sc_of(d)) begin
                  m_val[d][s] = 4'hF; m_blank[d][s] = 1'b0; m_err[d][s] = 1'b1;
                  if (seg_in == 7'h7F) begin
                     m_blank[d][s] = 1'b1; m_err[d][s] = 1'b0;
                  end
                  for (int v = 0; v < 10; v++)
                     if (pat[v] == seg_in) begin
                        m_val[d][s] = 4'(v); m_err[d][s] = 1'b0;
                     end
                  m_upd[d] = 1'b1; m_idx[d] = digit_idx;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            logic [15:0] ed;
            logic [3:0]  eb, ee;
            for (int k = 0; k < 4; k++) begin
               ed[4*k +: 4] = m_val[d][k]; eb[k] = m_blank[d][k]; ee[k] = m_err[d][k];
            end
            check(d == 0 ? "a_digits" : "b_digits", d == 0 ? a_digits : b_digits, ed);
            check(d == 0 ? "a_blank"  : "b_blank",  d == 0 ? a_blank  : b_blank,  eb);
            check(d == 0 ? "a_err"    : "b_err",    d == 0 ? a_err    : b_err,    ee);
            check(d == 0 ? "a_update" : "b_update", d == 0 ? a_update : b_update, m_upd[d]);
            if (m_upd[d])
               check(d == 0 ? "a_upd_idx" : "b_upd_idx", d == 0 ? a_idx : b_idx, m_idx[d]);
         end
      end
   end

   task automatic strobe(input logic [2:0] idx, input logic [6:0] seg);
      @(negedge clk);
      seg_in = seg; digit_idx = idx; seg_strobe = 1'b1;
      @(negedge clk);
      seg_strobe = 1'b0;
      $display("[TB] strobe slot=%0d seg=%b -> a upd=%0d dig=%h | b upd=%0d dig=%h",
               idx, seg, a_update, a_digits, b_update, b_digits);
   endtask

   initial begin
      rst = 1'b1; seg_in = 7'h7F; digit_idx = 3'd0; seg_strobe = 1'b0;
      #7 chk_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_digits", a_digits, 16'hFFFF);
      check("rst_blank", a_blank, 4'hF);
      check("rst_err", a_err, 4'h0);
      check("rst_update", a_update, 1'b0);

      // Slot 0 stabilises on 2; the fourth repeat must stay silent.
      strobe(0, 7'b0100100);
      check("b_first_commit", b_digits[3:0], 4'd2);
      check("a_no_commit_1", a_update, 1'b0);
      strobe(0, 7'b0100100);
      strobe(0, 7'b0100100);
      check("a_s0_val2", a_digits[3:0], 4'd2);
      check("a_s0_blank0", a_blank[0], 1'b0);
      check("a_s0_update", a_update, 1'b1);
      check("a_s0_idx", a_idx, 3'd0);
      strobe(0, 7'b0100100);
      check("a_s0_repeat_quiet", a_update, 1'b0);

      // Slot 1: a broken run of 3 never commits; 5 commits after its own third strobe.
      strobe(1, 7'b0110000);
      strobe(1, 7'b0110000);
      check("a_s1_no3", a_digits[7:4], 4'hF);
      strobe(1, 7'b0010010);
      strobe(1, 7'b0010010);
      check("a_s1_pending", a_update, 1'b0);
      strobe(1, 7'b0010010);
      check("a_s1_val5", a_digits[7:4], 4'd5);

      // Slot 2: hex A is an error, then 1 clears it.
      repeat (3) strobe(2, 7'b0001000);
      check("a_s2_errval", a_digits[11:8], 4'hF);
      check("a_s2_err", a_err[2], 1'b1);
      check("a_s2_blank", a_blank[2], 1'b0);
      repeat (3) strobe(2, 7'b1111001);
      check("a_s2_val1", a_digits[11:8], 4'd1);
      check("a_s2_errclr", a_err[2], 1'b0);

      // Interleaved slots keep independent runs.
      for (int i = 0; i < 3; i++) begin
         strobe(0, 7'b0000000);
         if (i == 2) begin
            check("a_il_s0_upd", a_update, 1'b1);
            check("a_il_s0_idx", a_idx, 3'd0);
            check("a_il_s0_val", a_digits[3:0], 4'd8);
         end
         strobe(3, 7'b1111000);
         if (i == 2) begin
            check("a_il_s3_upd", a_update, 1'b1);
            check("a_il_s3_idx", a_idx, 3'd3);
            check("a_il_s3_val", a_digits[15:12], 4'd7);
         end
      end

      // Out-of-range slot is ignored.
      strobe(5, 7'b1000000);
      check("a_oor_upd", a_update, 1'b0);
      check("b_oor_upd", b_update, 1'b0);
      check("a_oor_digits", a_digits, 16'h7158);

      // Reset mid-debounce, with a strobe in the same cycle.
      strobe(0, 7'b0010000);
      strobe(0, 7'b0010000);
      @(negedge clk);
      rst = 1'b1; seg_strobe = 1'b1; digit_idx = 3'd0; seg_in = 7'b0010000;
      @(negedge clk);
      rst = 1'b0; seg_strobe = 1'b0;
      check("a_mid_rst_digits", a_digits, 16'hFFFF);
      check("a_mid_rst_blank", a_blank, 4'hF);
      check("a_mid_rst_upd", a_update, 1'b0);
      strobe(0, 7'b0010000);
      check("a_post_rst_noupd", a_update, 1'b0);
      check("a_post_rst_digit", a_digits[3:0], 4'hF);

      // Single-strobe build: every decode, then blank, each commits once.
      for (int v = 0; v < 11; v++) begin
         strobe(1, v < 10 ? pat[v] : 7'h7F);
         check("b_dec_upd", b_update, 1'b1);
         check("b_dec_val", b_digits[7:4], v < 10 ? 4'(v) : 4'hF);
         check("b_dec_blank", b_blank[1], v == 10);
         strobe(1, v < 10 ? pat[v] : 7'h7F);
         check("b_dec_repeat_quiet", b_update, 1'b0);
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
